vx_cache_flush_ctrl: RTL and testbench

Flush sequencer placed in front of a `VX_cache_wrap` instance. On a flush request it closes the core request ports and waits for in-flight core reads to return. It then walks every line/way index, broadcasting a flush op to all banks, and waits for the memory side to go idle before signalling completion. It owns no datapath; it only gates handshakes and sequences the cache.

---
 rtl/vx_cache_flush_ctrl_if.sv | 42 ++++
 rtl/vx_cache_flush_ctrl.sv | 120 ++++++++++++
 tb/tb_vx_cache_flush_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_cache_flush_ctrl_if.sv
// rtl/vx_cache_flush_ctrl_if.sv - handshake bundle between the flush sequencer, core requesters and the cache
interface vx_cache_flush_ctrl_if #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 1,
  parameter int NUM_LINES = 64,
  parameter int NUM_WAYS  = 1
);
  localparam int AW = $clog2(NUM_LINES);
  localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic                 flush_req_valid;
  logic                 flush_req_ready;
  logic                 flush_done;
  logic                 flush_busy;
  logic [NUM_REQS-1:0]  core_req_valid_in;
  logic [NUM_REQS-1:0]  core_req_rw_in;
  logic [NUM_REQS-1:0]  core_req_ready_in;
  logic [NUM_REQS-1:0]  core_req_valid_out;
  logic [NUM_REQS-1:0]  core_req_ready_out;
  logic [NUM_REQS-1:0]  core_rsp_fire;
  logic                 flush_valid;
  logic [AW-1:0]        flush_addr;
  logic [WW-1:0]        flush_way;
  logic [NUM_BANKS-1:0] flush_ready;
  logic                 mem_idle;

  // Sequencer side
  modport slave (
    input  flush_req_valid, core_req_valid_in, core_req_rw_in, core_req_ready_out,
           core_rsp_fire, flush_ready, mem_idle,
    output flush_req_ready, flush_done, flush_busy, core_req_ready_in,
           core_req_valid_out, flush_valid, flush_addr, flush_way
  );

  // Environment side: requesters, cache banks and flush initiator
  modport master (
    output flush_req_valid, core_req_valid_in, core_req_rw_in, core_req_ready_out,
           core_rsp_fire, flush_ready, mem_idle,
    input  flush_req_ready, flush_done, flush_busy, core_req_ready_in,
           core_req_valid_out, flush_valid, flush_addr, flush_way
  );
endinterface

// File: rtl/vx_cache_flush_ctrl.sv
// rtl/vx_cache_flush_ctrl.sv - cache flush sequencer: drain core reads, walk all lines/ways, wait for memory idle
module vx_cache_flush_ctrl #(
  parameter int NUM_REQS    = 4,
  parameter int NUM_BANKS   = 1,
  parameter int NUM_LINES   = 64,
  parameter int NUM_WAYS    = 1,
  parameter int MAX_PENDING = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_cache_flush_ctrl_if.slave   bus
);
  localparam int AW    = $clog2(NUM_LINES);
  localparam int WW    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int TOTAL = NUM_LINES * NUM_WAYS;
  localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CW    = $clog2(NUM_REQS * MAX_PENDING + 1);
  localparam int SW    = CW + 1;
  localparam int PW    = $clog2(NUM_REQS + 1);
  localparam int XW    = AW + WW;
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_WALK,
    S_WAIT_MEM,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_pend;

  logic                w_block;
  logic [NUM_REQS-1:0] w_rd_fire;
  logic [PW-1:0]       w_inc;
  logic [PW-1:0]       w_dec;
  logic [SW-1:0]       w_sum;
  logic                w_underflow;
  logic [CW-1:0]       w_pend_nxt;
  logic                w_flush_all;
  logic [XW-1:0]       w_idx_ext;

  // Core ports are closed in every state except IDLE; responses are never gated.
  assign w_block                = (r_state != S_IDLE);
  assign bus.core_req_valid_out = bus.core_req_valid_in  & {NUM_REQS{~w_block}};
  assign bus.core_req_ready_in  = bus.core_req_ready_out & {NUM_REQS{~w_block}};

  // Only reads that actually fire expect a response; writes are fire-and-forget.
  assign w_rd_fire = bus.core_req_valid_out & bus.core_req_ready_out & ~bus.core_req_rw_in;

  // Popcounts of read issues and response returns this cycle
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_inc = w_inc + PW'(w_rd_fire[i]);
      w_dec = w_dec + PW'(bus.core_rsp_fire[i]);
    end
  end

  // Net the increments and decrements; a response with nothing outstanding clamps at zero.
  assign w_sum       = {1'b0, r_pend} + SW'(w_inc);
  assign w_underflow = (w_sum < SW'(w_dec));
  assign w_pend_nxt  = w_underflow ? '0 : CW'(w_sum - SW'(w_dec));

  // A broadcast op completes only once every bank has taken it in the same cycle.
  assign w_flush_all = &bus.flush_ready;

  // Walk index is {way, line}; zero-extension leaves way at 0 for direct-mapped caches.
  assign w_idx_ext      = XW'(r_idx);
  assign bus.flush_addr = w_idx_ext[AW-1:0];
  assign bus.flush_way  = w_idx_ext[XW-1:AW];

  assign bus.flush_req_ready = (r_state == S_IDLE);
  assign bus.flush_busy      = w_block;
  assign bus.flush_done      = (r_state == S_DONE);
  assign bus.flush_valid     = (r_state == S_WALK);

  // Flush sequencer and outstanding-read counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_pend  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      case (r_state)
        S_IDLE: begin
          if (bus.flush_req_valid) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pend_nxt == '0) begin
            r_state <= S_WALK;
            r_idx   <= '0;
          end
        end
        S_WALK: begin
          if (w_flush_all) begin
            if (r_idx == LAST_IDX) r_state <= S_WAIT_MEM;
            else                   r_idx   <= r_idx + IW'(1);
          end
        end
        S_WAIT_MEM: begin
          if (bus.mem_idle) r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A response without a matching outstanding read is a requester protocol error.
  a_pend_no_underflow: assert property (@(posedge clk) disable iff (!reset) !w_underflow);

endmodule

// File: tb/tb_vx_cache_flush_ctrl.sv
// tb/tb_vx_cache_flush_ctrl.sv - self-checking bench for vx_cache_flush_ctrl
module tb_vx_cache_flush_ctrl;
  localparam int NR = 4;
  localparam int NB = 2;
  localparam int NL = 4;
  localparam int NW = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  vx_cache_flush_ctrl_if #(.NUM_REQS(NR), .NUM_BANKS(NB), .NUM_LINES(NL), .NUM_WAYS(NW)) bus ();

  vx_cache_flush_ctrl #(
    .NUM_REQS(NR), .NUM_BANKS(NB), .NUM_LINES(NL), .NUM_WAYS(NW), .MAX_PENDING(16)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       freq;
    logic [3:0] vin;
    logic [3:0] rw;
    logic [3:0] rdy;
    logic       midle;
    logic       e_rrdy;
    logic       e_busy;
    logic       e_done;
    logic       e_fv;
    logic       chk_a;
    logic [2:0] e_idx;
    logic [3:0] e_vout;
    logic [3:0] e_rin;
  } vec_t;

  vec_t tv[15];

  function automatic vec_t mk(input logic freq, input logic [3:0] vin, input logic [3:0] rw,
                              input logic [3:0] rdy, input logic midle, input logic e_rrdy,
                              input logic e_busy, input logic e_done, input logic e_fv,
                              input logic chk_a, input logic [2:0] e_idx,
                              input logic [3:0] e_vout, input logic [3:0] e_rin);
    vec_t v;
    v.freq = freq; v.vin = vin; v.rw = rw; v.rdy = rdy; v.midle = midle;
    v.e_rrdy = e_rrdy; v.e_busy = e_busy; v.e_done = e_done; v.e_fv = e_fv;
    v.chk_a = chk_a; v.e_idx = e_idx; v.e_vout = e_vout; v.e_rin = e_rin;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush_req_valid    = 1'b0;
    bus.core_req_valid_in  = '0;
    bus.core_req_rw_in     = '0;
    bus.core_req_ready_out = '0;
    bus.core_rsp_fire      = '0;
    bus.flush_ready        = '1;
    bus.mem_idle           = 1'b1;
  endtask

  task automatic wait_done(input string nm, input int max, output int n);
    int found;
    found = 0;
    n = 0;
    for (int k = 1; k <= max; k++) begin
      tick();
      idle_inputs();
      @(negedge clk);
      n = k;
      if (bus.flush_done) begin
        found = 1;
        break;
      end
    end
    chk(nm, 32'(found), 32'd1);
  endtask

  function automatic logic [2:0] cur_idx();
    return {bus.flush_way, bus.flush_addr};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    int kd;
    int e4[13];
    logic [14:0] act;
    logic [14:0] exp;

    total = 0;
    bad   = 0;

    tv[0]  = mk(0, 4'b1010, 4'hF, 4'b0110, 1, 1, 0, 0, 0, 1, 3'd0, 4'b1010, 4'b0110);
    tv[1]  = mk(1, 4'b0101, 4'hF, 4'hF,    1, 1, 0, 0, 0, 1, 3'd0, 4'b0101, 4'hF);
    tv[2]  = mk(0, 4'hF,    4'hF, 4'hF,    1, 0, 1, 0, 0, 1, 3'd0, 4'h0,    4'h0);
    for (int k = 0; k < 8; k++)
      tv[3+k] = mk(0, 4'hF, 4'hF, 4'hF, 1, 0, 1, 0, 1, 1, 3'(k), 4'h0, 4'h0);
    tv[11] = mk(0, 4'hF, 4'hF, 4'hF, 1, 0, 1, 0, 0, 0, 3'd0, 4'h0, 4'h0);
    tv[12] = mk(1, 4'hF, 4'hF, 4'hF, 1, 0, 1, 1, 0, 0, 3'd0, 4'h0, 4'h0);
    tv[13] = mk(0, 4'hF, 4'hF, 4'hF, 1, 1, 0, 0, 0, 0, 3'd0, 4'hF, 4'hF);
    tv[14] = mk(0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 0, 0, 3'd0, 4'h0, 4'h0);

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, gating, idle flush walk order and 11-cycle latency
    for (int i = 0; i < 15; i++) begin
      tick();
      idle_inputs();
      bus.flush_req_valid    = tv[i].freq;
      bus.core_req_valid_in  = tv[i].vin;
      bus.core_req_rw_in     = tv[i].rw;
      bus.core_req_ready_out = tv[i].rdy;
      bus.mem_idle           = tv[i].midle;
      @(negedge clk);
      act = {bus.flush_req_ready, bus.flush_busy, bus.flush_done, bus.flush_valid,
             (tv[i].chk_a ? cur_idx() : 3'd0), bus.core_req_valid_out, bus.core_req_ready_in};
      exp = {tv[i].e_rrdy, tv[i].e_busy, tv[i].e_done, tv[i].e_fv,
             (tv[i].chk_a ? tv[i].e_idx : 3'd0), tv[i].e_vout, tv[i].e_rin};
      chk($sformatf("vec[%0d]", i), 32'(act), 32'(exp));
    end

    // Three reads outstanding, write in acceptance cycle, drain on third response
    tick(); idle_inputs();
    bus.core_req_valid_in = 4'b0111; bus.core_req_ready_out = 4'b0111;
    tick(); idle_inputs();
    bus.flush_req_valid = 1'b1;
    bus.core_req_valid_in = 4'b1000; bus.core_req_rw_in = 4'b1000; bus.core_req_ready_out = 4'b1000;
    @(negedge clk);
    chk("s2_accept_ready", 32'(bus.flush_req_ready), 32'd1);
    tick(); idle_inputs();
    bus.core_req_valid_in = 4'hF; bus.core_req_ready_out = 4'hF;
    @(negedge clk);
    chk("s2_gate_ready_in", 32'(bus.core_req_ready_in), 32'd0);
    chk("s2_gate_valid_out", 32'(bus.core_req_valid_out), 32'd0);
    tick(); idle_inputs(); bus.core_rsp_fire = 4'b0001;
    @(negedge clk); chk("s2_drain_1", 32'(bus.flush_valid), 32'd0);
    tick(); idle_inputs();
    @(negedge clk); chk("s2_drain_2", 32'(bus.flush_valid), 32'd0);
    tick(); idle_inputs(); bus.core_rsp_fire = 4'b0010;
    @(negedge clk); chk("s2_drain_3", 32'(bus.flush_valid), 32'd0);
    tick(); idle_inputs(); bus.core_rsp_fire = 4'b0100;
    @(negedge clk); chk("s2_drain_4", 32'(bus.flush_valid), 32'd0);
    tick(); idle_inputs();
    @(negedge clk);
    chk("s2_walk_start", 32'({bus.flush_valid, cur_idx()}), 32'({1'b1, 3'd0}));
    wait_done("s2_done_seen", 40, n);
    chk("s2_done_cycle", 32'(n), 32'd9);

    // Two read fires and two responses in the acceptance cycle net to zero
    tick(); idle_inputs();
    bus.core_req_valid_in = 4'b0011; bus.core_req_ready_out = 4'b0011;
    tick(); idle_inputs();
    bus.flush_req_valid = 1'b1;
    bus.core_req_valid_in = 4'b1100; bus.core_req_ready_out = 4'b1100; bus.core_rsp_fire = 4'b0011;
    @(negedge clk); chk("s3_accept_vout", 32'(bus.core_req_valid_out), 32'h0000000C);
    tick(); idle_inputs(); bus.core_rsp_fire = 4'b0001;
    @(negedge clk); chk("s3_drain_1", 32'(bus.flush_valid), 32'd0);
    tick(); idle_inputs(); bus.core_rsp_fire = 4'b0010;
    @(negedge clk); chk("s3_drain_2", 32'(bus.flush_valid), 32'd0);
    tick(); idle_inputs();
    @(negedge clk);
    chk("s3_walk_start", 32'({bus.flush_valid, cur_idx()}), 32'({1'b1, 3'd0}));
    wait_done("s3_done_seen", 40, n);
    tick(); idle_inputs();

    // Bank 1 stalls five cycles at idx 2
    e4 = '{0, 1, 2, 2, 2, 2, 2, 2, 3, 4, 5, 6, 7};
    bus.flush_req_valid = 1'b1;
    tick(); idle_inputs();
    @(negedge clk); chk("s4_drain", 32'(bus.flush_valid), 32'd0);
    for (int c = 0; c < 13; c++) begin
      tick(); idle_inputs();
      bus.flush_ready = (c >= 2 && c <= 6) ? 2'b01 : 2'b11;
      @(negedge clk);
      chk($sformatf("s4_walk[%0d]", c), 32'({bus.flush_valid, cur_idx()}), 32'({1'b1, 3'(e4[c])}));
    end
    tick(); idle_inputs();
    @(negedge clk); chk("s4_wait_mem", 32'({bus.flush_valid, bus.flush_done}), 32'd0);
    tick(); idle_inputs();
    @(negedge clk); chk("s4_done", 32'(bus.flush_done), 32'd1);

    // mem_idle low for seven cycles after the walk
    tick(); idle_inputs();
    bus.flush_req_valid = 1'b1;
    kd = 0;
    for (int k = 1; k <= 30; k++) begin
      tick(); idle_inputs();
      bus.mem_idle = (k >= 17);
      bus.core_req_valid_in = 4'hF; bus.core_req_ready_out = 4'hF;
      @(negedge clk);
      if (k >= 10) chk($sformatf("s5_blocked[%0d]", k), 32'(bus.core_req_ready_in), 32'd0);
      if (bus.flush_done) begin
        kd = k;
        break;
      end
    end
    chk("s5_done_cycle", 32'(kd), 32'd18);
    tick(); idle_inputs();
    bus.core_req_ready_out = 4'hF;
    @(negedge clk); chk("s5_unblocked", 32'(bus.core_req_ready_in), 32'h0000000F);

    // Reset mid-walk at idx 5, then a pending count cleared by reset
    tick(); idle_inputs();
    bus.flush_req_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(); idle_inputs();
    end
    @(negedge clk);
    chk("s6_at_idx5", 32'({bus.flush_valid, cur_idx()}), 32'({1'b1, 3'd5}));
    rst_n = 1'b0;
    tick(); idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("s6_after_reset",
        32'({bus.flush_busy, bus.flush_valid, cur_idx(), bus.flush_req_ready, bus.flush_done}),
        32'({1'b0, 1'b0, 3'd0, 1'b1, 1'b0}));
    tick(); idle_inputs();
    bus.core_req_valid_in = 4'b0011; bus.core_req_ready_out = 4'b0011;
    tick(); idle_inputs();
    rst_n = 1'b0;
    tick(); idle_inputs();
    rst_n = 1'b1;
    bus.flush_req_valid = 1'b1;
    tick(); idle_inputs();
    @(negedge clk); chk("s6_drain", 32'(bus.flush_valid), 32'd0);
    tick(); idle_inputs();
    @(negedge clk);
    chk("s6_restart_idx0", 32'({bus.flush_valid, cur_idx()}), 32'({1'b1, 3'd0}));
    wait_done("s6_done_seen", 40, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
